alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 5-bit AND/ROL ALU: accepts a command, iterates R back into A, returns result and flags.
// Optional early exit on a zero result is enabled by defining ALU_SEQ_ZF_EXIT_EN.
module alu_cmd_sequencer #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cf,
    input  logic             alu_sf,
    input  logic             alu_zf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_r,
    output logic             res_cf,
    output logic             res_sf,
    output logic             res_zf,
    output logic [CNT_W-1:0] res_iters,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // EXEC  | one ALU pass per cycle, R fed back into A
    // DONE  | result held on res_* until res_ready
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_reg;
    logic             op_reg;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] iters;
    logic             cf;
    logic             sf;
    logic             zf;
    logic             exit_now;

`ifdef ALU_SEQ_ZF_EXIT_EN
    // A zero accumulator cannot become nonzero again under AND or ROL.
    assign exit_now = (remaining == CNT_W'(1)) || alu_zf;
`else
    assign exit_now = (remaining == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            b_reg     <= '0;
            op_reg    <= 1'b0;
            remaining <= '0;
            iters     <= '0;
            cf        <= 1'b0;
            sf        <= 1'b0;
            zf        <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        acc       <= cmd_a;
                        b_reg     <= cmd_b;
                        op_reg    <= cmd_op;
                        remaining <= cmd_cnt;
                        iters     <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (cmd_cnt == '0) begin
                            cf        <= 1'b0;
                            sf        <= cmd_a[WIDTH-1];
                            zf        <= (cmd_a == '0);
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc       <= alu_r;
                    cf        <= alu_cf;
                    sf        <= alu_sf;
                    zf        <= alu_zf;
                    iters     <= iters + CNT_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    if (exit_now) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = acc;
    assign alu_b     = b_reg;
    assign alu_op    = op_reg;
    assign res_r     = acc;
    assign res_cf    = cf;
    assign res_sf    = sf;
    assign res_zf    = zf;
    assign res_iters = iters;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural AND/ROL ALU, result scoreboard, per-scenario tasks.
// Expectations follow ALU_SEQ_ZF_EXIT_EN when it is defined for the build.
module tb_alu_cmd_sequencer;
    localparam int W = 5;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, cmd_op;
    logic [W-1:0] cmd_a, cmd_b;
    logic [C-1:0] cmd_cnt;
    logic [W-1:0] alu_a, alu_b, alu_r;
    logic         alu_op, alu_cf, alu_sf, alu_zf;
    logic         res_valid, res_ready, res_cf, res_sf, res_zf, busy;
    logic [W-1:0] res_r;
    logic [C-1:0] res_iters;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cf;
        logic         sf;
        logic         zf;
        logic [C-1:0] iters;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_r(res_r), .res_cf(res_cf), .res_sf(res_sf), .res_zf(res_zf),
        .res_iters(res_iters), .busy(busy)
    );

    // Returns {CF, R}; ROL rotates A left by B mod W, CF is the last bit rotated out.
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [2*W-1:0] d;
        logic [W-1:0]   r;
        int             sh;
        if (!op) return {1'b0, a & b};
        sh = int'(b) % W;
        d  = {a, a} << sh;
        r  = d[2*W-1:W];
        return {(sh != 0) ? r[0] : 1'b0, r};
    endfunction

    assign {alu_cf, alu_r} = alu_fn(alu_a, alu_b, alu_op);
    assign alu_sf = alu_r[W-1];
    assign alu_zf = (alu_r == '0);

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic op, input logic [C-1:0] cnt);
        exp_t       e;
        logic [W:0] o;
        e.r     = a;
        e.cf    = 1'b0;
        e.sf    = a[W-1];
        e.zf    = (a == '0);
        e.iters = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            o       = alu_fn(e.r, b, op);
            e.r     = o[W-1:0];
            e.cf    = o[W];
            e.sf    = e.r[W-1];
            e.zf    = (e.r == '0);
            e.iters = e.iters + 1'b1;
`ifdef ALU_SEQ_ZF_EXIT_EN
            if (e.zf) break;
`endif
        end
        return e;
    endfunction

    // Handshake occurs on the following rising edge; res_ready only changes just after rising edges.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got r=%b iters=%0d, no result was expected", res_r, res_iters);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if ({res_r, res_cf, res_sf, res_zf, res_iters} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_result: got r=%b cf=%b sf=%b zf=%b iters=%0d, want r=%b cf=%b sf=%b zf=%b iters=%0d",
                             res_r, res_cf, res_sf, res_zf, res_iters,
                             mon_e.r, mon_e.cf, mon_e.sf, mon_e.zf, mon_e.iters);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic [C-1:0] cnt);
        int n = 0;
        sb.push_back(model(a, b, op, cnt));
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_cnt = cnt; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = W'($urandom);
        cmd_cnt   = C'($urandom);
    endtask

    // Starts at the negedge after the accept edge; lat = cycles until res_valid, bcy = busy cycles.
    task automatic observe(output int lat, output int bcy);
        lat = -1;
        bcy = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid && lat < 0) lat = i;
            if (!busy) break;
            bcy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({res_valid, busy, alu_a, alu_b, alu_op, res_r, res_iters, res_cf, res_sf, res_zf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b alu_a=%b alu_b=%b r=%b iters=%0d, want all 0",
                     res_valid, busy, alu_a, alu_b, res_r, res_iters);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b valid=%b busy=%b, want 1 0 0", cmd_ready, res_valid, busy);
        end
    endtask

    task automatic test_and;
        int lat, bcy;
        res_ready = 1'b1;
        send(5'b10110, 5'b01111, 1'b0, 3'd1);
        observe(lat, bcy);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL and_latency: got %0d, want 1", lat); end
        checks++;
        if (bcy != 2) begin errors++; $display("FAIL and_busy: got %0d, want 2", bcy); end
    endtask

    task automatic test_rol;
        int lat, bcy;
        res_ready = 1'b1;
        send(5'b10000, 5'b00001, 1'b1, 3'd3);
        observe(lat, bcy);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL rol_latency: got %0d, want 3", lat); end
        checks++;
        if (bcy != 4) begin errors++; $display("FAIL rol_busy: got %0d, want 4", bcy); end
    endtask

    task automatic test_cnt_zero;
        int lat, bcy;
        res_ready = 1'b1;
        send(5'b10000, 5'b00111, 1'b0, 3'd0);
        checks++;
        if (alu_a !== 5'b10000 || alu_b !== 5'b00111 || alu_op !== 1'b0) begin
            errors++;
            $display("FAIL cnt0_alu_drive: alu_a=%b alu_b=%b op=%b, want 10000 00111 0", alu_a, alu_b, alu_op);
        end
        observe(lat, bcy);
        checks++;
        if (lat != 0 || bcy != 1) begin
            errors++;
            $display("FAIL cnt0_timing: lat=%0d busy=%0d, want 0 1", lat, bcy);
        end
    endtask

    task automatic test_zf_exit;
        int lat, bcy;
`ifdef ALU_SEQ_ZF_EXIT_EN
        int want = 1;
`else
        int want = 4;
`endif
        res_ready = 1'b1;
        send(5'b10101, 5'b01010, 1'b0, 3'd4);
        observe(lat, bcy);
        checks++;
        if (lat != want) begin errors++; $display("FAIL zf_latency: got %0d, want %0d", lat, want); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   n = 0;
        e = model(5'b11011, 5'b00110, 1'b0, 3'd2);
        res_ready = 1'b0;
        send(5'b11011, 5'b00110, 1'b0, 3'd2);
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = i[0];
            cmd_a     = W'($urandom);
            cmd_cnt   = C'($urandom);
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || {res_r, res_cf, res_sf, res_zf, res_iters} !== e) begin
                errors++;
                $display("FAIL bp_hold: valid=%b r=%b iters=%0d, want 1 %b %0d", res_valid, res_r, res_iters, e.r, e.iters);
            end
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready: got %b, want 0", cmd_ready); end
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b cmd_ready=%b busy=%b, want 0 1 0", res_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_reset_mid_exec;
        int   lat, bcy;
        logic seen = 1'b0;
        res_ready = 1'b1;
        send(5'b00011, 5'b00001, 1'b1, 3'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, busy, alu_a, alu_b, alu_op, res_r, res_iters} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%b busy=%b alu_a=%b r=%b iters=%0d, want all 0",
                     res_valid, busy, alu_a, res_r, res_iters);
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result: res_valid seen=%b, want 0", seen); end
        send(5'b01001, 5'b00010, 1'b1, 3'd2);
        observe(lat, bcy);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL rst_mid_recover: latency %0d, want 2", lat); end
    endtask

    task automatic test_back_to_back;
        int           lat, bcy;
        logic [W-1:0] a, b;
        logic         op;
        logic [C-1:0] cnt;
        exp_t         e;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            op  = 1'($urandom);
            cnt = (k == 0) ? 3'd7 : C'($urandom);
            e   = model(a, b, op, cnt);
            send(a, b, op, cnt);
            observe(lat, bcy);
            checks++;
            if (lat != int'(e.iters) || bcy != int'(e.iters) + 1) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: lat=%0d busy=%0d, want %0d %0d", k, lat, bcy, e.iters, int'(e.iters) + 1);
            end
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 1'b0; cmd_cnt = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset;
        test_and;
        test_rol;
        test_cnt_zero;
        test_zf_exit;
        test_backpressure;
        test_reset_mid_exec;
        test_back_to_back;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d results outstanding, want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
